fetch_redirect_unit: RTL and testbench
======================================

Name: fetch_redirect_unit

Overview:
- IF-stage fetch controller, directly downstream of the ID-stage branch condition logic.
- Consumes the taken-branch decision and target, owns the PC register, and issues requests to a multi-cycle instruction memory.
- Drives the IF/ID pipeline register, including its valid (flush) bit.
- Handles hazard freeze, redirect while a fetch is outstanding, and buffering of a response that arrives while frozen.

Parameters:
- WORD_LEN, 32, datapath/address width (shared `WORD_LEN` define).
- RESET_PC, 0, PC value loaded on reset.
- PC_STEP, 4, sequential PC increment in bytes.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset; clk and rst are the only clock and reset.
- freeze  in  1  hazard stall; IF/ID and PC advance held.
- br_taken  in  1  branch/jump taken, from ID condition logic.
- br_target  in  WORD_LEN  redirect byte address; word-aligned.
- imem_req  out  1  fetch request.
- imem_addr  out  WORD_LEN  fetch address; equals pc.
- imem_ready  in  1  one-cycle pulse; imem_rdata valid this cycle.
- imem_rdata  in  WORD_LEN  fetched instruction.
- ifid_instr  out  WORD_LEN  IF/ID instruction register.
- ifid_pc  out  WORD_LEN  IF/ID PC+PC_STEP of that instruction.
- ifid_valid  out  1  IF/ID holds a real instruction; 0 means bubble.
- pc  out  WORD_LEN  current fetch PC.

Behaviour:
- Reset (rst=0, async):
  - pc=RESET_PC; ifid_instr=0, ifid_pc=0, ifid_valid=0.
  - state=REQ; hold buffer cleared; imem_req forced 0 while rst=0.
- Redirect qualifier: redirect = br_taken & ~freeze. br_taken is ignored while freeze=1 because ID operands are stale.
- States: REQ (request outstanding), KILL (outstanding request to discard), HOLD (response buffered, IF/ID frozen).
- imem_req = 1 in REQ and KILL, 0 in HOLD.
- imem_addr = pc. pc never changes while imem_req=1 and imem_ready=0 (address stable until response).
- REQ, ready=0:
  - redirect -> KILL; pending_target=br_target; ifid_valid<=0.
  - otherwise, freeze=0 -> ifid_valid<=0 (bubble).
  - otherwise, freeze=1 -> IF/ID holds.
- REQ, ready=1:
  - redirect -> discard rdata; pc<=br_target; ifid_valid<=0; stay REQ.
  - freeze=0 -> ifid_instr<=rdata, ifid_pc<=pc+PC_STEP, ifid_valid<=1; pc<=pc+PC_STEP; stay REQ.
  - freeze=1 -> buf_instr<=rdata, buf_pc<=pc+PC_STEP; pc<=pc+PC_STEP; -> HOLD; IF/ID holds.
- KILL:
  - redirect -> pending_target<=br_target (latest wins).
  - ready=1 -> discard rdata; pc<=pending_target; -> REQ.
  - While in KILL, ifid_valid<=0 unless freeze=1 (then IF/ID holds).
- HOLD:
  - freeze=1 -> hold everything.
  - freeze=0, no redirect -> IF/ID<=buffer, ifid_valid<=1; -> REQ (next request at pc).
  - freeze=0 with redirect -> drop buffer; pc<=br_target; ifid_valid<=0; -> REQ.
- Redirect latency: the first instruction from br_target appears in IF/ID one cycle after the imem_ready that returns it.
- Every redirect flushes the IF/ID instruction (ifid_valid<=0); there is no delay slot.
- Arithmetic: pc+PC_STEP wraps modulo 2^WORD_LEN with no flag. br_target low 2 bits are used as-is; alignment is the producer's responsibility.
- Reset mid-fetch: state returns to REQ immediately. A late imem_ready arriving while rst=0 is ignored.

Decomposition:
- Shared defines.v: `WORD_LEN`; new `FETCH_REQ`, `FETCH_KILL`, `FETCH_HOLD` 2-bit state encodings.
- One sub-module is natural: pc_incrementer (WORD_LEN adder of PC_STEP), reused for both pc and ifid_pc.

Test Plan:
- Sequential fetch: reset, ready every cycle -> imem_addr 0,4,8,...; ifid_pc 4,8,12 with ifid_valid=1 from the cycle after the first ready.
- Redirect with ready same cycle: pc=0x10, br_taken=1, br_target=0x40, ready=1 -> rdata discarded, ifid_valid=0, next imem_addr=0x40.
- Redirect during 3-cycle wait: request at 0x20, br_taken at cycle 1 with target 0x80, then again at cycle 2 with 0x90 -> response at cycle 3 discarded; next imem_addr=0x90; 0x80 never fetched.
- Freeze at response: freeze=1 when ready returns rdata=0xDEADBEEF at pc=0x8 -> imem_req=0 and IF/ID unchanged while frozen. On freeze release, ifid_instr=0xDEADBEEF, ifid_pc=0xC, imem_addr=0xC.
- br_taken under freeze: freeze=1, br_taken=1, target=0x100 -> no redirect; pc unchanged; state unchanged.
- Async reset mid-KILL: rst low between clock edges -> outputs zero immediately, imem_req=0; after release, first imem_addr=RESET_PC.

Source files
------------

// File: rtl/fetch_redirect_unit_pkg.sv
// Shared widths and fetch FSM state encodings for the IF-stage redirect unit.
package fetch_redirect_unit_pkg;

  localparam int DEF_WORD_LEN = 32;

  typedef enum logic [1:0] {
    FETCH_REQ  = 2'b00,
    FETCH_KILL = 2'b01,
    FETCH_HOLD = 2'b10
  } fetch_state_e;

endpackage

// File: rtl/fetch_redirect_unit_pc_incrementer.sv
// Sequential-PC adder; wraps modulo 2^WORD_LEN with no carry out.
module pc_incrementer
  import fetch_redirect_unit_pkg::*;
#(
  parameter int WORD_LEN = DEF_WORD_LEN,
  parameter int PC_STEP  = 4
) (
  input  logic [WORD_LEN-1:0] i_pc,
  output logic [WORD_LEN-1:0] o_pc_next
);

  assign o_pc_next = i_pc + WORD_LEN'(PC_STEP);

endmodule

// File: rtl/fetch_redirect_unit.sv
// IF-stage fetch controller: owns the PC, talks to a multi-cycle imem and
// drives the IF/ID register, handling freeze, redirects and in-flight kills.
module fetch_redirect_unit
  import fetch_redirect_unit_pkg::*;
#(
  parameter int                   WORD_LEN = DEF_WORD_LEN,
  parameter logic [WORD_LEN-1:0]  RESET_PC = '0,
  parameter int                   PC_STEP  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                freeze,
  input  logic                br_taken,
  input  logic [WORD_LEN-1:0] br_target,
  output logic                imem_req,
  output logic [WORD_LEN-1:0] imem_addr,
  input  logic                imem_ready,
  input  logic [WORD_LEN-1:0] imem_rdata,
  output logic [WORD_LEN-1:0] ifid_instr,
  output logic [WORD_LEN-1:0] ifid_pc,
  output logic                ifid_valid,
  output logic [WORD_LEN-1:0] pc
);

  fetch_state_e        r_state;
  logic [WORD_LEN-1:0] r_pc;
  logic [WORD_LEN-1:0] r_pending;
  logic [WORD_LEN-1:0] r_buf_instr;
  logic [WORD_LEN-1:0] r_buf_pc;
  logic [WORD_LEN-1:0] r_ifid_instr;
  logic [WORD_LEN-1:0] r_ifid_pc;
  logic                r_ifid_valid;
  logic [WORD_LEN-1:0] w_pc_next;
  logic                w_redirect;

  // ID operands are stale during a freeze, so a taken branch then is not trusted.
  assign w_redirect = br_taken & ~freeze;

  pc_incrementer #(
    .WORD_LEN (WORD_LEN),
    .PC_STEP  (PC_STEP)
  ) u_pc_inc (
    .i_pc      (r_pc),
    .o_pc_next (w_pc_next)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= FETCH_REQ;
      r_pc         <= RESET_PC;
      r_pending    <= '0;
      r_buf_instr  <= '0;
      r_buf_pc     <= '0;
      r_ifid_instr <= '0;
      r_ifid_pc    <= '0;
      r_ifid_valid <= 1'b0;
    end else begin
      case (r_state)
        FETCH_REQ: begin
          if (imem_ready) begin
            if (w_redirect) begin
              r_pc         <= br_target;
              r_ifid_valid <= 1'b0;
            end else if (!freeze) begin
              r_ifid_instr <= imem_rdata;
              r_ifid_pc    <= w_pc_next;
              r_ifid_valid <= 1'b1;
              r_pc         <= w_pc_next;
            end else begin
              r_buf_instr <= imem_rdata;
              r_buf_pc    <= w_pc_next;
              r_pc        <= w_pc_next;
              r_state     <= FETCH_HOLD;
            end
          end else if (w_redirect) begin
            // Address must stay stable until the response, so park the target.
            r_pending    <= br_target;
            r_ifid_valid <= 1'b0;
            r_state      <= FETCH_KILL;
          end else if (!freeze) begin
            r_ifid_valid <= 1'b0;
          end
        end
        FETCH_KILL: begin
          if (!freeze) r_ifid_valid <= 1'b0;
          if (w_redirect) r_pending <= br_target;
          if (imem_ready) begin
            r_pc    <= w_redirect ? br_target : r_pending;
            r_state <= FETCH_REQ;
          end
        end
        FETCH_HOLD: begin
          if (!freeze) begin
            if (w_redirect) begin
              r_pc         <= br_target;
              r_ifid_valid <= 1'b0;
            end else begin
              r_ifid_instr <= r_buf_instr;
              r_ifid_pc    <= r_buf_pc;
              r_ifid_valid <= 1'b1;
            end
            r_state <= FETCH_REQ;
          end
        end
        default: r_state <= FETCH_REQ;
      endcase
    end
  end

  assign imem_req   = rst & (r_state != FETCH_HOLD);
  assign imem_addr  = r_pc;
  assign pc         = r_pc;
  assign ifid_instr = r_ifid_instr;
  assign ifid_pc    = r_ifid_pc;
  assign ifid_valid = r_ifid_valid;

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Scoreboard bench for fetch_redirect_unit: directed fetch/redirect/freeze/reset vectors.
module tb_fetch_redirect_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        freeze;
  logic        br_taken;
  logic [31:0] br_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc;
  logic        ifid_valid;
  logic [31:0] pc;

  int errors = 0;
  int checks = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  fetch_redirect_unit #(.WORD_LEN(32), .RESET_PC(32'h0), .PC_STEP(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .freeze     (freeze),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .ifid_instr (ifid_instr),
    .ifid_pc    (ifid_pc),
    .ifid_valid (ifid_valid),
    .pc         (pc)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ID consumes the IF/ID entry on any cycle it is valid and not frozen.
  always @(negedge clk) begin
    if (rst === 1'b1 && ifid_valid === 1'b1 && freeze === 1'b0) begin
      logic [63:0] e;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ifid: got instr %h pc %h expected none", ifid_instr, ifid_pc);
      end else begin
        e = exp_q.pop_front();
        chk("sb_instr", ifid_instr, e[63:32]);
        chk("sb_pc", ifid_pc, e[31:0]);
      end
    end
  end

  task automatic drive(input logic f, input logic bt, input logic [31:0] tgt,
                       input logic rdy, input logic [31:0] rd);
    freeze     = f;
    br_taken   = bt;
    br_target  = tgt;
    imem_ready = rdy;
    imem_rdata = rd;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; freeze = 1'b0; br_taken = 1'b0; br_target = '0;
    imem_ready = 1'b0; imem_rdata = '0;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_pc", pc, 32'h0);
    chk("rst_req", {31'b0, imem_req}, 32'h0);
    chk("rst_valid", {31'b0, ifid_valid}, 32'h0);
    chk("rst_instr", ifid_instr, 32'h0);
    chk("rst_ifid_pc", ifid_pc, 32'h0);
    rst = 1'b1;
    #1;
    chk("req_after_rst", {31'b0, imem_req}, 32'h1);

    // Sequential fetch with ready every cycle.
    for (int i = 0; i < 4; i++) begin
      chk("seq_addr", imem_addr, 32'(i * 4));
      exp_q.push_back({32'h1000_0000 + 32'(i * 4), 32'(i * 4 + 4)});
      drive(1'b0, 1'b0, '0, 1'b1, 32'h1000_0000 + 32'(i * 4));
      chk("seq_valid", {31'b0, ifid_valid}, 32'h1);
    end

    // Redirect with ready in the same cycle: response discarded.
    chk("rd_addr_pre", imem_addr, 32'h10);
    drive(1'b0, 1'b1, 32'h40, 1'b1, 32'hBAD0_0010);
    chk("rd_valid", {31'b0, ifid_valid}, 32'h0);
    chk("rd_addr", imem_addr, 32'h40);
    drive(1'b0, 1'b1, 32'h20, 1'b1, 32'hBAD0_0040);
    chk("rd2_addr", imem_addr, 32'h20);

    // Two redirects during a 3-cycle wait; latest target wins.
    drive(1'b0, 1'b0, '0, 1'b0, '0);
    chk("kill_addr0", imem_addr, 32'h20);
    drive(1'b0, 1'b1, 32'h80, 1'b0, '0);
    chk("kill_addr1", imem_addr, 32'h20);
    chk("kill_req", {31'b0, imem_req}, 32'h1);
    drive(1'b0, 1'b1, 32'h90, 1'b0, '0);
    chk("kill_addr2", imem_addr, 32'h20);
    drive(1'b0, 1'b0, '0, 1'b1, 32'hBAD0_0020);
    chk("kill_addr_new", imem_addr, 32'h90);
    chk("kill_valid", {31'b0, ifid_valid}, 32'h0);
    exp_q.push_back({32'h2000_0090, 32'h94});
    drive(1'b0, 1'b0, '0, 1'b1, 32'h2000_0090);

    // Freeze when the response at 0x8 returns.
    drive(1'b0, 1'b1, 32'h4, 1'b1, 32'hBAD0_0094);
    exp_q.push_back({32'h3000_0004, 32'h8});
    drive(1'b0, 1'b0, '0, 1'b1, 32'h3000_0004);
    exp_q.push_back({32'hDEAD_BEEF, 32'hC});
    drive(1'b1, 1'b0, '0, 1'b1, 32'hDEAD_BEEF);
    chk("hold_req", {31'b0, imem_req}, 32'h0);
    chk("hold_instr", ifid_instr, 32'h3000_0004);
    chk("hold_ifid_pc", ifid_pc, 32'h8);
    // Taken branch under freeze is ignored.
    drive(1'b1, 1'b1, 32'h100, 1'b0, '0);
    chk("hold_br_pc", pc, 32'hC);
    chk("hold_br_req", {31'b0, imem_req}, 32'h0);
    chk("hold_br_instr", ifid_instr, 32'h3000_0004);
    drive(1'b0, 1'b0, '0, 1'b0, '0);
    chk("rel_instr", ifid_instr, 32'hDEAD_BEEF);
    chk("rel_ifid_pc", ifid_pc, 32'hC);
    chk("rel_addr", imem_addr, 32'hC);
    chk("rel_req", {31'b0, imem_req}, 32'h1);
    drive(1'b0, 1'b0, '0, 1'b0, '0);

    // Taken branch under freeze while requesting: no KILL, response is kept.
    drive(1'b1, 1'b1, 32'h100, 1'b0, '0);
    chk("frz_br_pc", pc, 32'hC);
    exp_q.push_back({32'h4000_000C, 32'h10});
    drive(1'b0, 1'b0, '0, 1'b1, 32'h4000_000C);
    chk("frz_br_addr", imem_addr, 32'h10);

    // PC wrap at the top of the address space.
    drive(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 32'hBAD0_0010);
    chk("wrap_pre", imem_addr, 32'hFFFF_FFFC);
    exp_q.push_back({32'h5000_FFFC, 32'h0});
    drive(1'b0, 1'b0, '0, 1'b1, 32'h5000_FFFC);
    chk("wrap_addr", imem_addr, 32'h0);

    // Async reset while in KILL, with a late ready during reset.
    drive(1'b0, 1'b1, 32'h200, 1'b0, '0);
    br_taken = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("arst_pc", pc, 32'h0);
    chk("arst_req", {31'b0, imem_req}, 32'h0);
    chk("arst_valid", {31'b0, ifid_valid}, 32'h0);
    chk("arst_instr", ifid_instr, 32'h0);
    chk("arst_ifid_pc", ifid_pc, 32'h0);
    drive(1'b0, 1'b0, '0, 1'b1, 32'hBAD0_0200);
    chk("arst_late_pc", pc, 32'h0);
    chk("arst_late_valid", {31'b0, ifid_valid}, 32'h0);
    imem_ready = 1'b0;
    rst = 1'b1;
    #1;
    chk("post_rst_addr", imem_addr, 32'h0);
    chk("post_rst_req", {31'b0, imem_req}, 32'h1);
    exp_q.push_back({32'h6000_0000, 32'h4});
    drive(1'b0, 1'b0, '0, 1'b1, 32'h6000_0000);
    drive(1'b0, 1'b0, '0, 1'b0, '0);
    drive(1'b0, 1'b0, '0, 1'b0, '0);

    chk("sb_drained", 32'(exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
